// File: rtl/ram_readout_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_readout_sched_pkg
// Description : Shared widths, state encoding and helpers for the readout
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_readout_sched_pkg;

    localparam int N_CH_DEF       = 2;
    localparam int DATA_WIDTH_DEF = 12;
    localparam int CNT_W          = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEL      = 3'd1,
        S_REQ      = 3'd2,
        S_WAIT_RDY = 3'd3,
        S_XFER     = 3'd4,
        S_FIN      = 3'd5
    } sched_state_e;

    // Channel tag width never drops below one bit, even for a single channel.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_readout_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_readout_sched_if
// Description : Command, ram_controller bank and merged-stream signals of the
//               readout scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_readout_sched_if #(
    parameter int N_CH       = ram_readout_sched_pkg::N_CH_DEF,
    parameter int DATA_WIDTH = ram_readout_sched_pkg::DATA_WIDTH_DEF,
    parameter int CH_W       = ram_readout_sched_pkg::ch_width(N_CH)
);
    logic                       start;
    logic [N_CH-1:0]            ch_en;
    logic [15:0]                n_samples;
    logic [15:0]                n_samples_o;
    logic [N_CH-1:0]            rqst_buff_o;
    logic [N_CH-1:0]            data_ack_o;
    logic [N_CH*DATA_WIDTH-1:0] ch_data;
    logic [N_CH-1:0]            ch_rdy;
    logic [DATA_WIDTH-1:0]      out_data;
    logic                       out_rdy;
    logic                       out_ack;
    logic [CH_W-1:0]            out_ch;
    logic                       out_sof;
    logic                       out_eof;
    logic                       busy;
    logic                       done;

    modport master (
        input  start, ch_en, n_samples, ch_data, ch_rdy, out_ack,
        output n_samples_o, rqst_buff_o, data_ack_o, out_data, out_rdy,
               out_ch, out_sof, out_eof, busy, done
    );

    modport slave (
        output start, ch_en, n_samples, ch_data, ch_rdy, out_ack,
        input  n_samples_o, rqst_buff_o, data_ack_o, out_data, out_rdy,
               out_ch, out_sof, out_eof, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/ram_readout_sched_next_ch.sv
`default_nettype none
// ============================================================================
// Module      : sched_next_ch
// Description : Lowest-set-bit finder selecting the next channel to read out.
// Revision    : 1.0 - initial release
// ============================================================================
module sched_next_ch #(
    parameter int N_CH = 2,
    parameter int CH_W = 1
) (
    input  logic [N_CH-1:0] mask_i,
    output logic [CH_W-1:0] idx_o,
    output logic            valid_o
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o   = CH_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_readout_sched.sv
`default_nettype none
// ============================================================================
// Module      : ram_readout_sched
// Description : Requests each enabled ram_controller buffer in ascending order
//               and merges their sample streams into one tagged stream.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_readout_sched
    import ram_readout_sched_pkg::*;
#(
    parameter int N_CH       = N_CH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CH_W       = ch_width(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_readout_sched_if.master  bus
);

    sched_state_e           state_q;
    logic [N_CH-1:0]        mask_q;
    logic [CH_W-1:0]        cur_q;
    logic [CNT_W-1:0]       remaining_q;
    logic [CNT_W-1:0]       n_samples_q;
    logic [N_CH-1:0]        rqst_q;
    logic                   busy_q;
    logic                   done_q;

    logic [CH_W-1:0]        w_next_idx;
    logic                   w_next_valid;
    logic                   w_xfer;
    logic                   w_rdy;
    logic                   w_ack;

    function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [N_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    sched_next_ch #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_next_ch (
        .mask_i  (mask_q),
        .idx_o   (w_next_idx),
        .valid_o (w_next_valid)
    );

    // The merged stream is a pure pass-through of the selected channel.
    assign w_xfer = (state_q == S_XFER);
    assign w_rdy  = w_xfer & bus.ch_rdy[cur_q];
    assign w_ack  = w_rdy & bus.out_ack;

    assign bus.out_rdy     = w_rdy;
    assign bus.data_ack_o  = w_ack ? onehot(cur_q) : '0;
    assign bus.out_data    = bus.ch_data[int'(cur_q) * DATA_WIDTH +: DATA_WIDTH];
    assign bus.out_ch      = cur_q;
    assign bus.out_sof     = w_xfer & (remaining_q == n_samples_q);
    assign bus.out_eof     = w_xfer & (remaining_q == CNT_W'(1));
    assign bus.n_samples_o = n_samples_q;
    assign bus.rqst_buff_o = rqst_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            cur_q       <= '0;
            remaining_q <= '0;
            n_samples_q <= '0;
            rqst_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rqst_q <= '0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        mask_q      <= bus.ch_en;
                        n_samples_q <= bus.n_samples;
                        busy_q      <= 1'b1;
                        state_q     <= S_SEL;
                    end
                end
                S_SEL: begin
                    // A zero count never issues a request: the buffer would underflow.
                    if (!w_next_valid || (n_samples_q == '0)) begin
                        state_q <= S_FIN;
                    end else begin
                        cur_q       <= w_next_idx;
                        mask_q      <= mask_q & ~onehot(w_next_idx);
                        remaining_q <= n_samples_q;
                        rqst_q      <= onehot(w_next_idx);
                        state_q     <= S_REQ;
                    end
                end
                S_REQ: begin
                    state_q <= S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    if (bus.ch_rdy[cur_q]) begin
                        state_q <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_ack) begin
                        if (remaining_q == CNT_W'(1)) begin
                            state_q <= S_SEL;
                        end else begin
                            remaining_q <= remaining_q - CNT_W'(1);
                        end
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_readout_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_readout_sched
// Description : Randomised scoreboard bench for the readout scheduler with a
//               behavioural ram_controller bank and sink.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_readout_sched;
    import ram_readout_sched_pkg::*;

    localparam int N_CH = 2;
    localparam int DW   = DATA_WIDTH_DEF;

    typedef struct {
        int            ch;
        logic [DW-1:0] d;
        bit            sof;
        bit            eof;
    } exp_t;

    logic clk;
    logic rst;

    ram_readout_sched_if #(.N_CH(N_CH), .DATA_WIDTH(DW)) bus ();

    ram_readout_sched #(.N_CH(N_CH), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            n_cmp;
    int            n_fail;
    int            done_cnt;
    int            ack_pct;
    bit            stall;
    exp_t          exp_q[$];
    int            rq_q[$];
    logic [DW-1:0] base [N_CH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Behavioural ram_controller bank: data_rdy two cycles after a request,
    // then one sample per ack with a random 0..2 cycle refill gap.
    initial begin : ram_model
        int               wt  [N_CH];
        int               idx [N_CH];
        logic [N_CH-1:0]  nxt_rdy;
        bus.ch_rdy  = '0;
        bus.ch_data = '0;
        for (int c = 0; c < N_CH; c++) begin
            wt[c]  = -1;
            idx[c] = 0;
        end
        forever begin
            @(negedge clk);
            for (int c = 0; c < N_CH; c++) begin
                nxt_rdy[c] = bus.ch_rdy[c];
                if (rst) begin
                    nxt_rdy[c] = 1'b0;
                    wt[c]      = -1;
                    idx[c]     = 0;
                end else if (bus.rqst_buff_o[c]) begin
                    idx[c]     = 0;
                    wt[c]      = 1;
                    nxt_rdy[c] = 1'b0;
                end else if (bus.data_ack_o[c]) begin
                    idx[c]++;
                    nxt_rdy[c] = 1'b0;
                    wt[c]      = (idx[c] < int'(bus.n_samples_o)) ? int'($urandom_range(0, 2)) : -1;
                end else if (wt[c] == 0) begin
                    nxt_rdy[c] = 1'b1;
                    wt[c]      = -1;
                end else if (wt[c] > 0) begin
                    wt[c]--;
                end
            end
            @(posedge clk);
            #1;
            bus.ch_rdy = nxt_rdy;
            for (int c = 0; c < N_CH; c++) begin
                bus.ch_data[c*DW +: DW] = base[c] + DW'(idx[c]);
            end
        end
    end

    initial begin : sink
        bus.out_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ack = (!stall && (int'($urandom_range(0, 99)) < ack_pct)) ? 1'b1 : 1'b0;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        int   rc;
        if (!rst) begin
            if (bus.out_rdy && bus.out_ack) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_sample: ch %0d data 0x%0h, expected none", bus.out_ch, bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_ch", 64'(bus.out_ch), 64'(e.ch));
                    check("out_data", 64'(bus.out_data), 64'(e.d));
                    check("out_sof", 64'(bus.out_sof), 64'(e.sof));
                    check("out_eof", 64'(bus.out_eof), 64'(e.eof));
                    check("data_ack_sel", 64'(bus.data_ack_o), 64'(1) << e.ch);
                end
            end else begin
                check("data_ack_idle", 64'(bus.data_ack_o), 64'(0));
            end
            if (|bus.rqst_buff_o) begin
                if (rq_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_rqst: rqst_buff_o 0x%0h, expected none", bus.rqst_buff_o);
                end else begin
                    rc = rq_q.pop_front();
                    check("rqst_buff", 64'(bus.rqst_buff_o), 64'(1) << rc);
                end
            end
            if (bus.done) done_cnt++;
        end
    end

    task automatic load_expect(input logic [N_CH-1:0] m, input int n, output int tot);
        exp_t e;
        tot = 0;
        for (int c = 0; c < N_CH; c++) begin
            base[c] = DW'($urandom);
            if (m[c] && n > 0) begin
                rq_q.push_back(c);
                for (int k = 0; k < n; k++) begin
                    e.ch  = c;
                    e.d   = base[c] + DW'(k);
                    e.sof = (k == 0);
                    e.eof = (k == n - 1);
                    exp_q.push_back(e);
                    tot++;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst       = 1'b1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        rq_q.delete();
        rst = 1'b0;
    endtask

    task automatic run(input logic [N_CH-1:0] m, input int n, input int pct,
                       input bit do_stall, input bit do_restart);
        int            tot, lat, limit, d0, sz;
        bit            stalled, restarted, empty;
        logic [DW-1:0] snap;
        ack_pct   = pct;
        empty     = (m == '0) || (n == 0);
        load_expect(m, n, tot);
        limit     = 60 + tot * 12;
        d0        = done_cnt;
        stalled   = 1'b0;
        restarted = 1'b0;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.ch_en     = m;
        bus.n_samples = 16'(n);
        lat = 0;
        while (1) begin
            @(posedge clk);
            lat++;
            if (lat == 1) begin
                #1;
                bus.start     = 1'b0;
                bus.ch_en     = N_CH'($urandom);
                bus.n_samples = 16'($urandom);
            end
            @(negedge clk); #1;
            if (lat == 1) check("busy_after_start", 64'(bus.busy), 64'(1));
            if (bus.done) break;
            if (lat >= limit) begin
                n_cmp++;
                n_fail++;
                $display("FAIL done_timeout: no done after %0d cycles, expected within %0d", lat, limit);
                do_reset();
                return;
            end
            if (do_stall && !stalled && exp_q.size() == tot - 1) begin
                stalled = 1'b1;
                stall   = 1'b1;
                repeat (6) begin @(negedge clk); #1; end
                sz   = exp_q.size();
                snap = bus.out_data;
                check("stall_rdy", 64'(bus.out_rdy), 64'(1));
                repeat (10) begin
                    @(negedge clk); #1;
                    check("stall_data", 64'(bus.out_data), 64'(snap));
                    check("stall_no_ack", 64'(bus.data_ack_o), 64'(0));
                end
                check("stall_remaining", 64'(exp_q.size()), 64'(sz));
                stall = 1'b0;
            end
            if (do_restart && !restarted && exp_q.size() <= tot / 2) begin
                restarted     = 1'b1;
                bus.start     = 1'b1;
                bus.ch_en     = ~m;
                bus.n_samples = 16'(n + 3);
                @(negedge clk); #1;
                bus.start = 1'b0;
                check("restart_n_samples", 64'(bus.n_samples_o), 64'(n));
                check("restart_busy", 64'(bus.busy), 64'(1));
            end
        end
        // Empty readout: accept edge, SEL->FIN edge, then FIN raises done.
        if (empty) check("empty_done_latency", 64'(lat), 64'(3));
        check("busy_at_done", 64'(bus.busy), 64'(0));
        check("samples_left", 64'(exp_q.size()), 64'(0));
        check("rqst_left", 64'(rq_q.size()), 64'(0));
        @(negedge clk); #1;
        check("done_width", 64'(bus.done), 64'(0));
        check("done_count", 64'(done_cnt - d0), 64'(1));
    endtask

    task automatic reset_mid();
        int tot, cnt;
        ack_pct = 80;
        load_expect(2'b11, 5, tot);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.ch_en     = 2'b11;
        bus.n_samples = 16'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cnt = 0;
        while (!(bus.out_ch == 1'b1 && bus.out_rdy) && cnt < 300) begin
            @(negedge clk); #1;
            cnt++;
        end
        check("reach_ch1_xfer", 64'(cnt < 300), 64'(1));
        rst = 1'b1;
        @(negedge clk); #1;
        check("reset_mid_outputs",
              64'({bus.busy, bus.done, bus.rqst_buff_o, bus.data_ack_o, bus.out_rdy,
                   bus.out_sof, bus.out_eof, bus.out_ch, bus.n_samples_o}), 64'(0));
        exp_q.delete();
        rq_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin : main
        n_cmp         = 0;
        n_fail        = 0;
        done_cnt      = 0;
        stall         = 1'b0;
        ack_pct       = 100;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.ch_en     = '0;
        bus.n_samples = '0;
        for (int c = 0; c < N_CH; c++) base[c] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("reset_outputs",
              64'({bus.busy, bus.done, bus.rqst_buff_o, bus.data_ack_o, bus.out_rdy,
                   bus.out_sof, bus.out_eof, bus.out_ch, bus.n_samples_o}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        run(2'b11, 4, 100, 1'b0, 1'b0);
        run(2'b10, 3, 100, 1'b0, 1'b0);
        run(2'b00, 5, 100, 1'b0, 1'b0);
        run(2'b11, 0, 100, 1'b0, 1'b0);
        run(2'b01, 6, 70, 1'b1, 1'b0);
        run(2'b11, 5, 60, 1'b0, 1'b1);
        reset_mid();
        run(2'b11, 2, 100, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run(N_CH'($urandom_range(0, 3)), int'($urandom_range(0, 8)),
                int'($urandom_range(30, 100)), 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
